// File: rtl/user_wb_fabric_pkg.sv
// Shared types and constants for the user Wishbone fabric.
// States, CSR offsets and canned response words.
package user_wb_fabric_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } fsm_t;

   localparam logic [31:0] CSR_PEND  = 32'h0;
   localparam logic [31:0] CSR_MASK  = 32'h4;
   localparam logic [31:0] CSR_TOCNT = 32'h8;

   localparam logic [31:0] DAT_UNMAPPED = 32'hBAD0_ADD0;
   localparam logic [31:0] DAT_TIMEOUT  = 32'hDEAD_DEAD;

endpackage

// File: rtl/user_wb_fabric_if.sv
// Upstream Wishbone classic port between the management SoC
// and the user fabric.
interface user_wb_fabric_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] wdat;
   logic [31:0] rdat;
   logic        ack;

   modport master (
      output cyc, stb, we, sel, adr, wdat,
      input  rdat, ack
   );

   modport slave (
      input  cyc, stb, we, sel, adr, wdat,
      output rdat, ack
   );
endinterface

// File: rtl/user_wb_fabric_csr.sv
// Local CSR slot: pending/mask interrupt registers, timeout counter
// and the masked interrupt reduction onto user_irq.
module user_wb_fabric_csr
   import user_wb_fabric_pkg::*;
#(
   parameter int N_SLV  = 4,
   parameter int N_IRQ  = 3,
   parameter int SLV_AW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              be0,
   input  logic [SLV_AW-1:0] adr,
   input  logic [N_SLV-1:0]  wdat,
   output logic [31:0]       rdat,
   input  logic              to_inc,
   input  logic [N_SLV-1:0]  slv_irq,
   output logic [N_IRQ-1:0]  user_irq
);

   logic [N_SLV-1:0] pend;
   logic [N_SLV-1:0] mask;
   logic [N_SLV-1:0] w1c;
   logic [7:0]       tocnt;
   logic [N_IRQ-1:0] irq_n;
   logic [31:0]      off;
   logic             wr_pend;
   logic             wr_mask;
   logic             wr_toc;

   assign off     = 32'(adr);
   assign wr_pend = wr && be0 && off == CSR_PEND;
   assign wr_mask = wr && be0 && off == CSR_MASK;
   assign wr_toc  = wr && be0 && off == CSR_TOCNT;
   assign w1c     = wr_pend ? wdat : '0;

   always_comb begin
      rdat = '0;
      unique case (1'b1)
         off == CSR_PEND:  rdat = 32'(pend);
         off == CSR_MASK:  rdat = 32'(mask);
         off == CSR_TOCNT: rdat = 32'(tocnt);
         default:          rdat = '0;
      endcase
   end

   // Slot i feeds irq line i mod N_IRQ
   always_comb begin
      irq_n = '0;
      for (int k = 0; k < N_IRQ; k++)
         for (int i = 0; i < N_SLV; i++)
            if (i % N_IRQ == k)
               irq_n[k] = irq_n[k] | (pend[i] & mask[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         mask     <= '0;
         tocnt    <= '0;
         user_irq <= '0;
      end else begin
         pend     <= (pend & ~w1c) | slv_irq;
         user_irq <= irq_n;
         if (wr_mask)
            mask <= wdat;
         if (wr_toc)
            tocnt <= '0;
         else if (to_inc && tocnt != 8'hFF)
            tocnt <= tocnt + 8'd1;
      end
   end

endmodule

// File: rtl/user_wb_fabric.sv
// Wishbone fabric: window decode onto N_SLV slots plus a CSR slot,
// registered request/response, per-access timeout.
module user_wb_fabric
   import user_wb_fabric_pkg::*;
#(
   parameter int          N_SLV   = 4,
   parameter int          SLV_AW  = 8,
   parameter logic [31:0] BASE    = 32'h3000_0000,
   parameter int          TIMEOUT = 255,
   parameter int          N_IRQ   = 3
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   user_wb_fabric_if.slave     wbs,
   output logic [N_SLV-1:0]    m_cyc_o,
   output logic [N_SLV-1:0]    m_stb_o,
   output logic                m_we_o,
   output logic [3:0]          m_sel_o,
   output logic [SLV_AW-1:0]   m_adr_o,
   output logic [31:0]         m_dat_o,
   input  logic [32*N_SLV-1:0] m_dat_i,
   input  logic [N_SLV-1:0]    m_ack_i,
   input  logic [N_SLV-1:0]    slv_irq_i,
   output logic [N_IRQ-1:0]    user_irq_o
);

   localparam int SEL_W = $clog2(N_SLV + 1);
   localparam int HI    = SLV_AW + SEL_W;
   localparam logic [SEL_W-1:0] CSR_SLOT = '1;

   fsm_t             state;
   logic [15:0]      tmr;
   logic [SEL_W-1:0] slot;
   logic             hit;
   logic             req;
   logic             is_slv;
   logic             is_csr;
   logic [N_SLV-1:0] dec;
   logic [31:0]      sdat;
   logic             ack_hit;
   logic             csr_wr;
   logic             to_inc;
   logic [31:0]      csr_rdat;

   assign hit    = wbs.adr[31:HI] == BASE[31:HI];
   assign slot   = wbs.adr[HI-1:SLV_AW];
   assign req    = state == IDLE && wbs.cyc && wbs.stb;
   assign is_slv = hit && int'(slot) < N_SLV;
   assign is_csr = hit && slot == CSR_SLOT;
   assign csr_wr = req && is_csr && wbs.we;

   assign m_stb_o = m_cyc_o;
   assign ack_hit = |(m_ack_i & m_cyc_o);
   assign to_inc  = state == WAIT && wbs.cyc && !ack_hit && tmr == '0;

   always_comb begin
      dec = '0;
      for (int i = 0; i < N_SLV; i++)
         if (slot == SEL_W'(i))
            dec[i] = 1'b1;
   end

   // m_cyc_o is one-hot, so it doubles as the read-data select
   always_comb begin
      sdat = '0;
      for (int i = 0; i < N_SLV; i++)
         if (m_cyc_o[i])
            sdat = m_dat_i[32*i +: 32];
   end

   user_wb_fabric_csr #(
      .N_SLV  (N_SLV),
      .N_IRQ  (N_IRQ),
      .SLV_AW (SLV_AW)
   ) u_csr (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .wr       (csr_wr),
      .be0      (wbs.sel[0]),
      .adr      (wbs.adr[SLV_AW-1:0]),
      .wdat     (wbs.wdat[N_SLV-1:0]),
      .rdat     (csr_rdat),
      .to_inc   (to_inc),
      .slv_irq  (slv_irq_i),
      .user_irq (user_irq_o)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state    <= IDLE;
         tmr      <= '0;
         m_cyc_o  <= '0;
         m_we_o   <= 1'b0;
         m_sel_o  <= '0;
         m_adr_o  <= '0;
         m_dat_o  <= '0;
         wbs.ack  <= 1'b0;
         wbs.rdat <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  unique case (1'b1)
                     is_slv: begin
                        m_cyc_o <= dec;
                        m_we_o  <= wbs.we;
                        m_sel_o <= wbs.sel;
                        m_adr_o <= wbs.adr[SLV_AW-1:0];
                        m_dat_o <= wbs.wdat;
                        tmr     <= 16'(TIMEOUT);
                        state   <= WAIT;
                     end
                     is_csr: begin
                        wbs.ack  <= 1'b1;
                        wbs.rdat <= csr_rdat;
                        state    <= RESP;
                     end
                     default: begin
                        wbs.ack  <= 1'b1;
                        wbs.rdat <= DAT_UNMAPPED;
                        state    <= RESP;
                     end
                  endcase
               end
            end
            WAIT: begin
               if (!wbs.cyc) begin
                  m_cyc_o <= '0;
                  state   <= IDLE;
               end else if (ack_hit) begin
                  m_cyc_o  <= '0;
                  wbs.ack  <= 1'b1;
                  wbs.rdat <= sdat;
                  state    <= RESP;
               end else if (tmr == '0) begin
                  m_cyc_o  <= '0;
                  wbs.ack  <= 1'b1;
                  wbs.rdat <= DAT_TIMEOUT;
                  state    <= RESP;
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            RESP: begin
               wbs.ack  <= 1'b0;
               wbs.rdat <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_user_wb_fabric.sv
// Directed bench for user_wb_fabric: slot access, timeout, unmapped,
// CSR/IRQ, abort and mid-transaction reset.
module tb_user_wb_fabric;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   m_cyc;
   logic [3:0]   m_stb;
   logic         m_we;
   logic [3:0]   m_sel;
   logic [7:0]   m_adr;
   logic [31:0]  m_dat;
   logic [127:0] m_dat_i;
   logic [3:0]   m_ack = '0;
   logic [3:0]   slv_irq = '0;
   logic [2:0]   user_irq;

   int total = 0;
   int bad = 0;

   localparam logic [31:0] D0 = 32'hA000_00A0;
   localparam logic [31:0] D1 = 32'hA111_11A1;
   localparam logic [31:0] D2 = 32'hA222_22A2;
   localparam logic [31:0] D3 = 32'hA333_33A3;

   user_wb_fabric_if wbs();

   user_wb_fabric dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wbs        (wbs),
      .m_cyc_o    (m_cyc),
      .m_stb_o    (m_stb),
      .m_we_o     (m_we),
      .m_sel_o    (m_sel),
      .m_adr_o    (m_adr),
      .m_dat_o    (m_dat),
      .m_dat_i    (m_dat_i),
      .m_ack_i    (m_ack),
      .slv_irq_i  (slv_irq),
      .user_irq_o (user_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // lat: slave acks in the lat-th cycle it sees m_cyc; <=0 never acks.
   task automatic access(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input int lat, output logic [31:0] rd,
                         output int n, output logic [3:0] c1,
                         output logic [7:0] a1, output logic [3:0] any);
      int  act;
      logic got;
      wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = w;
      wbs.adr = a; wbs.wdat = d; wbs.sel = s;
      rd = '0; n = -1; c1 = '0; a1 = '0; any = '0;
      act = 0; got = 1'b0;
      for (int c = 1; c <= 400 && !got; c++) begin
         tick();
         m_ack = '0;
         if (c == 1) begin
            c1 = m_cyc;
            a1 = m_adr;
         end
         any = any | m_cyc;
         if (wbs.ack) begin
            got = 1'b1;
            rd  = wbs.rdat;
            n   = c;
         end else if (m_cyc != '0) begin
            act++;
            if (act == lat)
               m_ack = m_cyc;
         end
      end
      wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
      tick();
   endtask

   logic [31:0] rd;
   int          n;
   logic [3:0]  c1;
   logic [7:0]  a1;
   logic [3:0]  any;
   logic        seen;

   initial begin
      m_dat_i = {D3, D2, D1, D0};
      wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
      wbs.sel = '0; wbs.adr = '0; wbs.wdat = '0;
      #2;
      chk("rst_ack", 32'(wbs.ack), 32'd0);
      chk("rst_rdat", wbs.rdat, 32'd0);
      chk("rst_cyc", 32'(m_cyc), 32'd0);
      chk("rst_irq", 32'(user_irq), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // 1: slot 1 write, slave acks in its 3rd cycle
      access(1'b1, 32'h3000_0104, 32'h1234_5678, 4'hF, 3, rd, n, c1, a1, any);
      chk("t1_cyc", 32'(c1), 32'h2);
      chk("t1_adr", 32'(a1), 32'h04);
      chk("t1_mdat", m_dat, 32'h1234_5678);
      chk("t1_mwe", 32'(m_we), 32'd1);
      chk("t1_lat", n, 32'd4);
      chk("t1_ackclr", 32'(wbs.ack), 32'd0);
      access(1'b0, 32'h3000_0100, 32'h0, 4'hF, 1, rd, n, c1, a1, any);
      chk("t1_rd", rd, D1);
      chk("t1_rdlat", n, 32'd2);
      chk("t1_rdatclr", wbs.rdat, 32'd0);

      // 2: slot 2 never acks
      access(1'b0, 32'h3000_0200, 32'h0, 4'hF, 0, rd, n, c1, a1, any);
      chk("t2_cyc", 32'(c1), 32'h4);
      chk("t2_dat", rd, 32'hDEAD_DEAD);
      chk("t2_lat", n, 32'd257);
      chk("t2_cycclr", 32'(m_cyc), 32'd0);
      access(1'b0, 32'h3000_0708, 32'h0, 4'hF, 0, rd, n, c1, a1, any);
      chk("t2_tocnt", rd, 32'd1);
      access(1'b1, 32'h3000_0708, 32'h0, 4'h1, 0, rd, n, c1, a1, any);
      access(1'b0, 32'h3000_0708, 32'h0, 4'hF, 0, rd, n, c1, a1, any);
      chk("t2_tocclr", rd, 32'd0);

      // 3: unmapped slot 5 and out-of-window
      access(1'b0, 32'h3000_0500, 32'h0, 4'hF, 1, rd, n, c1, a1, any);
      chk("t3_dat", rd, 32'hBAD0_ADD0);
      chk("t3_lat", n, 32'd1);
      chk("t3_nocyc", 32'(any), 32'd0);
      access(1'b1, 32'h2000_0100, 32'h5555_5555, 4'hF, 1, rd, n, c1, a1, any);
      chk("t3_miss", rd, 32'hBAD0_ADD0);
      chk("t3_misscyc", 32'(any), 32'd0);

      // 4: mask/pend/irq
      access(1'b1, 32'h3000_0704, 32'h5, 4'hF, 0, rd, n, c1, a1, any);
      chk("t4_csrlat", n, 32'd1);
      access(1'b1, 32'h3000_0704, 32'hF, 4'hE, 0, rd, n, c1, a1, any);
      access(1'b0, 32'h3000_0704, 32'h0, 4'hF, 0, rd, n, c1, a1, any);
      chk("t4_mask", rd, 32'h5);
      slv_irq = 4'b1000;
      tick();
      slv_irq = 4'b0000;
      tick(); tick();
      chk("t4_irq_masked", 32'(user_irq), 32'd0);
      slv_irq = 4'b0001;
      tick();
      chk("t4_irq_lag", 32'(user_irq), 32'd0);
      tick();
      chk("t4_irq", 32'(user_irq), 32'b001);
      access(1'b0, 32'h3000_0700, 32'h0, 4'hF, 0, rd, n, c1, a1, any);
      chk("t4_pend", rd, 32'h9);
      access(1'b1, 32'h3000_0700, 32'h1, 4'hF, 0, rd, n, c1, a1, any);
      access(1'b0, 32'h3000_0700, 32'h0, 4'hF, 0, rd, n, c1, a1, any);
      chk("t4_setwins", rd, 32'h9);
      slv_irq = 4'b0000;
      access(1'b1, 32'h3000_0700, 32'h9, 4'hF, 0, rd, n, c1, a1, any);
      access(1'b0, 32'h3000_0700, 32'h0, 4'hF, 0, rd, n, c1, a1, any);
      chk("t4_w1c", rd, 32'h0);
      chk("t4_irqclr", 32'(user_irq), 32'd0);

      // 5: abort in WAIT
      wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0;
      wbs.adr = 32'h3000_0000; wbs.sel = 4'hF;
      tick();
      chk("t5_cyc", 32'(m_cyc), 32'h1);
      wbs.cyc = 1'b0; wbs.stb = 1'b0;
      tick();
      chk("t5_drop", 32'(m_cyc), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen = seen | wbs.ack;
         tick();
      end
      chk("t5_noack", 32'(seen), 32'd0);
      access(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1, rd, n, c1, a1, any);
      chk("t5_next", rd, D0);
      chk("t5_nextlat", n, 32'd2);

      // 6: reset mid-WAIT, then retry
      wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0;
      wbs.adr = 32'h3000_0200; wbs.sel = 4'hF;
      tick(); tick();
      chk("t6_wait", 32'(m_cyc), 32'h4);
      rst_n = 1'b0;
      #1;
      chk("t6_cyc", 32'(m_cyc), 32'd0);
      chk("t6_adr", 32'(m_adr), 32'd0);
      chk("t6_ack", 32'(wbs.ack), 32'd0);
      chk("t6_irq", 32'(user_irq), 32'd0);
      wbs.cyc = 1'b0; wbs.stb = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      access(1'b0, 32'h3000_0200, 32'h0, 4'hF, 2, rd, n, c1, a1, any);
      chk("t6_retry", rd, D2);
      chk("t6_lat", n, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
